// File: rtl/iref_ctrl.sv
// Power-up sequencer for the IREF macro: releases pd, precharges, settles, then flags ready.
// Optional minimum power-down dwell (COOL state) is enabled by defining IREF_CTRL_MIN_OFF_EN.
module iref_ctrl #(
    parameter int CNT_W      = 16,
    parameter int OFF_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] charge_time,
    input  logic [CNT_W-1:0] settle_time,
    output logic             iref_pd,
    output logic             iref_charge,
    output logic             ready,
    output logic             busy
);

`ifdef IREF_CTRL_MIN_OFF_EN
    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_CHARGE = 3'd1,
        S_SETTLE = 3'd2,
        S_ON     = 3'd3,
        S_COOL   = 3'd4
    } state_t;

    localparam int COOL_W = (OFF_CYCLES > 1) ? $clog2(OFF_CYCLES) : 1;
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(OFF_CYCLES - 1);
    localparam state_t ABORT_STATE = S_COOL;
`else
    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_CHARGE = 2'd1,
        S_SETTLE = 2'd2,
        S_ON     = 2'd3
    } state_t;

    localparam state_t ABORT_STATE = S_OFF;
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] settle_reg, settle_next;
    logic             pd_next, charge_next, ready_next, busy_next;

`ifdef IREF_CTRL_MIN_OFF_EN
    logic [COOL_W-1:0] cool_reg, cool_next;
`endif

    // A zero duration still occupies one cycle in its state.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        settle_next = settle_reg;
`ifdef IREF_CTRL_MIN_OFF_EN
        cool_next   = cool_reg;
`endif
        case (state_reg)
            S_OFF: begin
                if (en) begin
                    state_next  = S_CHARGE;
                    cnt_next    = load_val(charge_time);
                    settle_next = settle_time;
                end
            end
            S_CHARGE: begin
                if (!en) begin
                    state_next = ABORT_STATE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = S_SETTLE;
                    cnt_next   = load_val(settle_reg);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (!en) begin
                    state_next = ABORT_STATE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = S_ON;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            S_ON: begin
                if (!en) begin
                    state_next = ABORT_STATE;
                    cnt_next   = '0;
                end
            end
`ifdef IREF_CTRL_MIN_OFF_EN
            S_COOL: begin
                // en is ignored until the dwell expires
                if (cool_reg == '0) begin
                    state_next = S_OFF;
                end else begin
                    cool_next = cool_reg - COOL_W'(1);
                end
            end
`endif
            default: begin
                state_next = S_OFF;
                cnt_next   = '0;
            end
        endcase
`ifdef IREF_CTRL_MIN_OFF_EN
        if (state_next == S_COOL && state_reg != S_COOL) begin
            cool_next = COOL_LOAD;
        end
`endif
    end

    // Outputs are decoded from the next state and registered alongside it, so they
    // change only on clock edges and track the state register exactly.
    always_comb begin
        pd_next     = 1'b1;
        charge_next = 1'b1;
        ready_next  = 1'b0;
        busy_next   = 1'b0;
        case (state_next)
            S_CHARGE: begin
                pd_next   = 1'b0;
                busy_next = 1'b1;
            end
            S_SETTLE: begin
                pd_next     = 1'b0;
                charge_next = 1'b0;
                busy_next   = 1'b1;
            end
            S_ON: begin
                pd_next     = 1'b0;
                charge_next = 1'b0;
                ready_next  = 1'b1;
            end
`ifdef IREF_CTRL_MIN_OFF_EN
            S_COOL: begin
                busy_next = 1'b1;
            end
`endif
            default: begin
                pd_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_OFF;
            cnt_reg     <= '0;
            settle_reg  <= '0;
            iref_pd     <= 1'b1;
            iref_charge <= 1'b1;
            ready       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            settle_reg  <= settle_next;
            iref_pd     <= pd_next;
            iref_charge <= charge_next;
            ready       <= ready_next;
            busy        <= busy_next;
        end
    end

`ifdef IREF_CTRL_MIN_OFF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cool_reg <= '0;
        end else begin
            cool_reg <= cool_next;
        end
    end
`endif

endmodule

// File: tb/tb_iref_ctrl.sv
// Scoreboard bench for iref_ctrl: scenario tasks queue per-cycle expected outputs
// {iref_pd, iref_charge, ready, busy}; a monitor pops and compares after each edge.
module tb_iref_ctrl;
    localparam int CNT_W = 16;
`ifdef IREF_CTRL_MIN_OFF_EN
    localparam int COOL_N = 32;
`else
    localparam int COOL_N = 0;
`endif

    localparam logic [3:0] V_OFF  = 4'b1100;
    localparam logic [3:0] V_CHG  = 4'b0101;
    localparam logic [3:0] V_SET  = 4'b0001;
    localparam logic [3:0] V_ON   = 4'b0010;
    localparam logic [3:0] V_COOL = 4'b1101;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [CNT_W-1:0] charge_time = '0;
    logic [CNT_W-1:0] settle_time = '0;
    logic             iref_pd, iref_charge, ready, busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [3:0] exp_q[$];
    string      tag_q[$];

    iref_ctrl #(.CNT_W(CNT_W), .OFF_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .charge_time(charge_time), .settle_time(settle_time),
        .iref_pd(iref_pd), .iref_charge(iref_charge), .ready(ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: one pop and one invariant check per clock edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            logic [3:0] got, want;
            string tag;
            got = {iref_pd, iref_charge, ready, busy};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow cyc=%0d got=%b required=queued entry", cyc, got);
            end else begin
                want = exp_q.pop_front();
                tag = tag_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got={pd,chg,rdy,busy}=%b required=%b", tag, cyc, got, want);
                end else begin
                    $display("cyc=%0d %s outputs=%b ok", cyc, tag, got);
                end
            end
            total++;
            if ((iref_pd && !iref_charge) !== 1'b0) begin
                bad++;
                $display("FAIL invariant cyc=%0d got pd=%b chg=%b required chg=1 while pd=1", cyc, iref_pd, iref_charge);
            end
        end
    end

    task automatic push_n(input logic [3:0] v, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(v);
            tag_q.push_back(tag);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic abort_to_off(input string tag, input int off_cycles);
        en = 1'b0;
        push_n(V_COOL, COOL_N, {tag, "_cool"});
        push_n(V_OFF, off_cycles, {tag, "_off"});
        wait_n(COOL_N + off_cycles);
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({iref_pd, iref_charge, ready, busy} !== V_OFF) begin
            bad++;
            $display("FAIL reset_state got=%b required=%b", {iref_pd, iref_charge, ready, busy}, V_OFF);
        end else begin
            $display("reset_state outputs=%b ok", {iref_pd, iref_charge, ready, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        push_n(V_OFF, 3, "idle");
        wait_n(3);
    endtask

    task automatic test_basic();
        charge_time = 16'd10;
        settle_time = 16'd5;
        en = 1'b1;
        push_n(V_CHG, 10, "basic_charge");
        push_n(V_SET, 5, "basic_settle");
        push_n(V_ON, 3, "basic_on");
        wait_n(18);
        abort_to_off("basic_drop", 2);
    endtask

    task automatic test_zero_times();
        charge_time = 16'd0;
        settle_time = 16'd0;
        en = 1'b1;
        push_n(V_CHG, 1, "zero_charge");
        push_n(V_SET, 1, "zero_settle");
        push_n(V_ON, 2, "zero_on");
        wait_n(4);
        abort_to_off("zero_drop", 2);
    endtask

    task automatic test_abort_settle();
        charge_time = 16'd10;
        settle_time = 16'd8;
        en = 1'b1;
        push_n(V_CHG, 10, "abort_charge");
        push_n(V_SET, 3, "abort_settle");
        wait_n(13);
        abort_to_off("abort", 2);
        en = 1'b1;
        push_n(V_CHG, 10, "rerun_charge");
        push_n(V_SET, 8, "rerun_settle");
        push_n(V_ON, 2, "rerun_on");
        wait_n(20);
        abort_to_off("rerun_drop", 2);
    endtask

    task automatic test_time_change();
        charge_time = 16'd10;
        settle_time = 16'd3;
        en = 1'b1;
        push_n(V_CHG, 10, "latch_charge");
        push_n(V_SET, 3, "latch_settle");
        push_n(V_ON, 2, "latch_on");
        wait_n(3);
        charge_time = 16'd2;
        settle_time = 16'd7;
        wait_n(12);
        abort_to_off("latch_drop", 2);
    endtask

    task automatic test_async_reset();
        charge_time = 16'd10;
        settle_time = 16'd5;
        en = 1'b1;
        push_n(V_CHG, 4, "areset_charge");
        wait_n(4);
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        total++;
        if ({iref_pd, iref_charge, ready, busy} !== V_OFF) begin
            bad++;
            $display("FAIL async_reset got=%b required=%b", {iref_pd, iref_charge, ready, busy}, V_OFF);
        end else begin
            $display("async_reset outputs=%b ok", {iref_pd, iref_charge, ready, busy});
        end
        push_n(V_OFF, 3, "areset_off");
        @(negedge clk);
        rst_n = 1'b1;
        wait_n(2);
        // the counter must have been cleared: a fresh short sequence follows
        charge_time = 16'd2;
        settle_time = 16'd1;
        en = 1'b1;
        push_n(V_CHG, 2, "post_reset_charge");
        push_n(V_SET, 1, "post_reset_settle");
        push_n(V_ON, 1, "post_reset_on");
        wait_n(4);
        abort_to_off("post_reset_drop", 2);
    endtask

`ifdef IREF_CTRL_MIN_OFF_EN
    task automatic test_cooldown();
        charge_time = 16'd3;
        settle_time = 16'd2;
        en = 1'b1;
        push_n(V_CHG, 3, "cool_charge");
        push_n(V_SET, 2, "cool_settle");
        push_n(V_ON, 2, "cool_on");
        wait_n(7);
        en = 1'b0;
        push_n(V_COOL, 32, "cool_dwell");
        push_n(V_OFF, 1, "cool_off");
        push_n(V_CHG, 3, "cool_rerun_charge");
        push_n(V_SET, 2, "cool_rerun_settle");
        push_n(V_ON, 1, "cool_rerun_on");
        wait_n(1);
        en = 1'b1;
        wait_n(38);
        abort_to_off("cool_final", 2);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_times();
        test_abort_settle();
        test_time_change();
        test_async_reset();
`ifdef IREF_CTRL_MIN_OFF_EN
        test_cooldown();
`endif
        mon_en = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d entries required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
